// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: prioritised stalls, exception redirect, and an
// uninterruptible-fetch drain. Define PIPE_CTRL_PERF_CNT_EN to build the perf counters.
module pipe_ctrl (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        fetch_busy,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ALL  = 6'b111111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;

  state_e      state_q, state_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] flush_pc_c;

  always_comb begin
    state_d    = state_q;
    saved_pc_d = saved_pc_q;
    stall_c    = STALL_NONE;
    flush_c    = 1'b0;
    flush_pc_c = 32'd0;
    case (state_q)
      RUN: begin
        if (exc_valid) begin
          // A pending instruction-bus transaction cannot be aborted, so hold the target until it retires
          if (fetch_busy) begin
            stall_c    = STALL_ALL;
            saved_pc_d = exc_target;
            state_d    = DRAIN;
          end else begin
            flush_c    = 1'b1;
            flush_pc_c = exc_target;
          end
        end else if (stallreq_mem) begin
          stall_c = STALL_MEM;
        end else if (stallreq_ex) begin
          stall_c = STALL_EX;
        end else if (stallreq_id) begin
          stall_c = STALL_ID;
        end else if (stallreq_if) begin
          stall_c = STALL_IF;
        end
      end
      DRAIN: begin
        stall_c = STALL_ALL;
        if (!fetch_busy) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        flush_c    = 1'b1;
        flush_pc_c = saved_pc_q;
        state_d    = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // Outputs are quiet for the whole reset interval, not just after the next edge
    if (!cpu_rst_n) begin
      stall_c    = STALL_NONE;
      flush_c    = 1'b0;
      flush_pc_c = 32'd0;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q    <= RUN;
      saved_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      saved_pc_q <= saved_pc_d;
    end
  end

  assign stall    = stall_c;
  assign flush    = flush_c;
  assign flush_pc = flush_pc_c;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Both counters stick at all-ones rather than wrapping
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_c[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (flush_c && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 16'd0;
`endif

endmodule
